// File: rtl/tl_uh_ram_slave_if.sv
// TileLink-UH A/D channel bundle between a master and tl_uh_ram_slave.
// Signal names keep the slave-side _i/_o suffixes so both ends read the same.
//   A channel: a_opcode/param/size/source/address/mask/data/valid -> slave, a_ready <- slave
//   D channel: d_opcode/param/size/source/sink/denied/data/corrupt/valid <- slave, d_ready -> slave
interface tl_uh_ram_slave_if #(
    parameter int ADDR_W   = 64,
    parameter int DATA_W   = 64,
    parameter int SOURCE_W = 4,
    parameter int SINK_W   = 2
);
    logic [2:0]          a_opcode_i;
    logic [2:0]          a_param_i;
    logic [2:0]          a_size_i;
    logic [SOURCE_W-1:0] a_source_i;
    logic [ADDR_W-1:0]   a_address_i;
    logic [7:0]          a_mask_i;
    logic [DATA_W-1:0]   a_data_i;
    logic                a_valid_i;
    logic                a_ready_o;

    logic [2:0]          d_opcode_o;
    logic [1:0]          d_param_o;
    logic [2:0]          d_size_o;
    logic [SOURCE_W-1:0] d_source_o;
    logic [SINK_W-1:0]   d_sink_o;
    logic                d_denied_o;
    logic [DATA_W-1:0]   d_data_o;
    logic                d_corrupt_o;
    logic                d_valid_o;
    logic                d_ready_i;

    modport master (
        output a_opcode_i, a_param_i, a_size_i, a_source_i, a_address_i,
               a_mask_i, a_data_i, a_valid_i, d_ready_i,
        input  a_ready_o, d_opcode_o, d_param_o, d_size_o, d_source_o,
               d_sink_o, d_denied_o, d_data_o, d_corrupt_o, d_valid_o
    );

    modport slave (
        input  a_opcode_i, a_param_i, a_size_i, a_source_i, a_address_i,
               a_mask_i, a_data_i, a_valid_i, d_ready_i,
        output a_ready_o, d_opcode_o, d_param_o, d_size_o, d_source_o,
               d_sink_o, d_denied_o, d_data_o, d_corrupt_o, d_valid_o
    );
endinterface

// File: rtl/tl_uh_ram_slave.sv
// TileLink-UH memory slave: Get / PutFullData / PutPartialData with bursts,
// backed by a DEPTH x 64-bit word array. One transaction in flight; the D
// response starts LATENCY idle cycles after the request ends.
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset
//   bus    : TileLink A/D channels (slave modport)
module tl_uh_ram_slave #(
    parameter int ADDR_W   = 64,
    parameter int DATA_W   = 64,
    parameter int DEPTH    = 4096,
    parameter int LATENCY  = 2,
    parameter int SOURCE_W = 4,
    parameter int SINK_W   = 2,
    parameter int SINK_ID  = 0
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    tl_uh_ram_slave_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] MEM_BYTES = (ADDR_W+1)'(DEPTH) << 3;
    localparam logic [3:0] LAT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    typedef enum logic [1:0] {S_IDLE, S_WBURST, S_WAIT, S_RESP} state_t;

    state_t              r_state;
    logic                r_a_ready;
    logic                r_d_valid;
    logic [2:0]          r_d_opcode;
    logic [2:0]          r_d_size;
    logic [SOURCE_W-1:0] r_d_source;
    logic                r_d_denied;
    logic                r_d_corrupt;
    logic [DATA_W-1:0]   r_d_data;
    logic                r_denied;
    logic                r_is_get;
    logic [4:0]          r_cnt;      // beats left in the current phase
    logic [IDX_W-1:0]    r_idx;      // word index of the current beat
    logic [3:0]          r_lat;

    logic [DATA_W-1:0]   r_mem [DEPTH];

    // Request decode, valid only for a first beat seen in IDLE.
    logic              w_hs;
    logic              w_is_get;
    logic              w_is_put;
    logic              w_op_ok;
    logic              w_size_ok;
    logic [7:0]        w_bytes;
    logic              w_align_ok;
    logic              w_range_ok;
    logic              w_legal;
    logic [4:0]        w_beats;
    logic [IDX_W-1:0]  w_idx;
    logic [IDX_W-1:0]  w_idx_nxt;
    logic              w_we;
    logic [IDX_W-1:0]  w_widx;
    logic              w_unused;

    assign w_hs       = r_a_ready & bus.a_valid_i;
    assign w_is_get   = (bus.a_opcode_i == 3'd4);
    assign w_is_put   = (bus.a_opcode_i == 3'd0) | (bus.a_opcode_i == 3'd1);
    assign w_op_ok    = w_is_get | w_is_put;
    assign w_size_ok  = (bus.a_size_i <= 3'd6);
    assign w_bytes    = 8'd1 << bus.a_size_i;
    assign w_align_ok = (bus.a_address_i[6:0] & (w_bytes[6:0] - 7'd1)) == 7'd0;
    // One extra bit so an address near the top of the space cannot wrap into range.
    assign w_range_ok = ({1'b0, bus.a_address_i} + (ADDR_W+1)'(w_bytes)) <= MEM_BYTES;
    assign w_legal    = w_op_ok & w_size_ok & w_align_ok & w_range_ok;
    // A bad opcode consumes exactly one beat; anything else follows the size.
    assign w_beats    = (!w_op_ok || bus.a_size_i <= 3'd3) ? 5'd1
                      : 5'd1 << (bus.a_size_i - 3'd3);
    assign w_idx      = bus.a_address_i[IDX_W+2:3];
    assign w_idx_nxt  = r_idx + 1'b1;
    assign w_unused   = ^bus.a_param_i;

    // Writes happen on the accepting edge of every legal Put beat; denied
    // bursts are drained without touching memory.
    assign w_we   = w_hs & (((r_state == S_IDLE) & w_legal & w_is_put) |
                            ((r_state == S_WBURST) & ~r_denied));
    assign w_widx = (r_state == S_IDLE) ? w_idx : r_idx;

    // Memory is deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (w_we) begin
            for (int b = 0; b < 8; b++) begin
                if (bus.a_mask_i[b]) r_mem[w_widx][8*b +: 8] <= bus.a_data_i[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= S_IDLE;
            r_a_ready   <= 1'b0;
            r_d_valid   <= 1'b0;
            r_d_opcode  <= '0;
            r_d_size    <= '0;
            r_d_source  <= '0;
            r_d_denied  <= 1'b0;
            r_d_corrupt <= 1'b0;
            r_d_data    <= '0;
            r_denied    <= 1'b0;
            r_is_get    <= 1'b0;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_lat       <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (!r_a_ready) begin
                        r_a_ready <= 1'b1;  // first cycle out of reset
                    end else if (bus.a_valid_i) begin
                        // Header is latched once here and held for the whole response.
                        r_denied    <= ~w_legal;
                        r_is_get    <= w_is_get;
                        r_d_opcode  <= w_is_get ? 3'd1 : 3'd0;
                        r_d_size    <= bus.a_size_i;
                        r_d_source  <= bus.a_source_i;
                        r_d_denied  <= ~w_legal;
                        r_d_corrupt <= w_is_get & ~w_legal;
                        // Prefetch the first Get word so LATENCY=0 still has data ready.
                        r_d_data    <= (w_is_get & w_legal) ? r_mem[w_idx] : '0;
                        if (!w_is_get && w_beats != 5'd1) begin
                            r_state <= S_WBURST;
                            r_cnt   <= w_beats - 5'd1;
                            r_idx   <= w_idx + 1'b1;
                        end else begin
                            r_a_ready <= 1'b0;
                            r_cnt     <= w_is_get ? w_beats : 5'd1;
                            r_idx     <= w_idx;
                            if (LATENCY == 0) begin
                                r_state   <= S_RESP;
                                r_d_valid <= 1'b1;
                            end else begin
                                r_state <= S_WAIT;
                                r_lat   <= LAT_INIT;
                            end
                        end
                    end
                end
                S_WBURST: begin
                    if (w_hs) begin
                        r_idx <= w_idx_nxt;
                        if (r_cnt == 5'd1) begin
                            r_a_ready <= 1'b0;
                            r_cnt     <= 5'd1;  // single AccessAck
                            if (LATENCY == 0) begin
                                r_state   <= S_RESP;
                                r_d_valid <= 1'b1;
                            end else begin
                                r_state <= S_WAIT;
                                r_lat   <= LAT_INIT;
                            end
                        end else begin
                            r_cnt <= r_cnt - 5'd1;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_lat == 4'd0) begin
                        r_state   <= S_RESP;
                        r_d_valid <= 1'b1;
                    end else begin
                        r_lat <= r_lat - 4'd1;
                    end
                end
                S_RESP: begin
                    if (bus.d_ready_i) begin
                        if (r_cnt == 5'd1) begin
                            r_state   <= S_IDLE;
                            r_d_valid <= 1'b0;
                            r_a_ready <= 1'b1;
                        end else begin
                            r_cnt    <= r_cnt - 5'd1;
                            r_idx    <= w_idx_nxt;
                            r_d_data <= (r_is_get & ~r_denied) ? r_mem[w_idx_nxt] : '0;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.a_ready_o   = r_a_ready;
    assign bus.d_valid_o   = r_d_valid;
    assign bus.d_opcode_o  = r_d_opcode;
    assign bus.d_param_o   = 2'b00;
    assign bus.d_size_o    = r_d_size;
    assign bus.d_source_o  = r_d_source;
    assign bus.d_sink_o    = SINK_W'(SINK_ID);
    assign bus.d_denied_o  = r_d_denied;
    assign bus.d_corrupt_o = r_d_corrupt;
    assign bus.d_data_o    = r_d_data;
endmodule
